// File: rtl/qvga_pkg.sv
// Shared constants and pixel-format helpers for the QVGA frame-buffer read path.
package qvga_pkg;

  localparam int DEF_IMG_WIDTH  = 320;
  localparam int DEF_IMG_HEIGHT = 240;
  localparam int FB_ADDR_W      = $clog2(DEF_IMG_WIDTH * DEF_IMG_HEIGHT);

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Keep the top four bits of each channel (green drops its LSB and top bit alignment to [10:7]).
  function automatic rgb444_t rgb565_to_444(input logic [15:0] pix);
    rgb444_t c;
    c.r = pix[15:12];
    c.g = pix[10:7];
    c.b = pix[4:1];
    return c;
  endfunction

endpackage

// File: rtl/qvga_fb_reader_if.sv
// Frame-buffer read port: the reader drives enable/address, the memory returns data.
interface qvga_fb_reader_if
  import qvga_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W
) ();

  logic              oe;
  logic [ADDR_W-1:0] rAddr;
  logic [15:0]       rData;

  modport master (output oe, output rAddr, input rData);
  modport slave  (input oe, input rAddr, output rData);

endinterface

// File: rtl/qvga_fb_reader_sync_delay_line.sv
// Fixed-depth shift register with a configurable reset pattern.
module sync_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_dly
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= sig;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign sig_dly = stage_q[DEPTH-1];

endmodule

// File: rtl/qvga_fb_reader.sv
// Reads a 320x240 RGB565 frame buffer for 640x480 VGA timing with 2x pixel/line
// doubling, returning RGB444 plus syncs aligned to the memory read latency.
module qvga_fb_reader
  import qvga_pkg::*;
#(
  parameter int          IMG_WIDTH    = DEF_IMG_WIDTH,
  parameter int          IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int          READ_LATENCY = 1,
  parameter logic [15:0] BLANK_COLOR  = 16'h0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    de_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  qvga_fb_reader_if.master        fb,
  output logic                    de_out,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic [3:0]              r_out,
  output logic [3:0]              g_out,
  output logic [3:0]              b_out
);

  localparam int ADDR_W = $clog2(IMG_WIDTH * IMG_HEIGHT);
  localparam int Y_W    = $clog2(IMG_HEIGHT + 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_WIDTH);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0]    Y_END    = Y_W'(IMG_HEIGHT);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(IMG_HEIGHT - 1);

  logic [ADDR_W-1:0] addr_cnt, line_base, next_base;
  logic [Y_W-1:0]    src_y;
  logic              h_dup, v_dup, x_done, de_d;
  logic              in_range, last_pix, line_end;
  logic [3:0]        ctrl_p0;
  rgb444_t           pix_p0;

  assign next_base = line_base + ROW_STEP;
  assign last_pix  = (addr_cnt - line_base) == ROW_LAST;
  // x_done marks "column offset reached IMG_WIDTH" without stepping addr_cnt
  // onto the next line, so rAddr stays inside the buffer on the last line.
  assign in_range  = (src_y < Y_END) && !x_done;
  assign line_end  = de_d && !de_in;

  assign fb.oe    = de_in && in_range;
  assign fb.rAddr = addr_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_cnt  <= '0;
      line_base <= '0;
      src_y     <= '0;
      h_dup     <= 1'b0;
      v_dup     <= 1'b0;
      x_done    <= 1'b0;
      de_d      <= 1'b0;
    end else begin
      de_d <= de_in;
      if (!vsync_in) begin
        addr_cnt  <= '0;
        line_base <= '0;
        src_y     <= '0;
        h_dup     <= 1'b0;
        v_dup     <= 1'b0;
        x_done    <= 1'b0;
      end else if (line_end) begin
        h_dup  <= 1'b0;
        x_done <= 1'b0;
        if (!v_dup) begin
          v_dup    <= 1'b1;
          addr_cnt <= line_base;
        end else begin
          v_dup <= 1'b0;
          // line_base parks on the last source line once the image is exhausted
          if (src_y < Y_LAST) begin
            line_base <= next_base;
            addr_cnt  <= next_base;
          end else begin
            addr_cnt <= line_base;
          end
          if (src_y < Y_END) src_y <= src_y + 1'b1;
        end
      end else if (de_in && in_range) begin
        h_dup <= ~h_dup;
        if (h_dup) begin
          if (last_pix) x_done   <= 1'b1;
          else          addr_cnt <= addr_cnt + 1'b1;
        end
      end
    end
  end

  // Stage p0: control delayed to meet rData; order {de, hsync, vsync, in_range}
  sync_delay_line #(
    .WIDTH   (4),
    .DEPTH   (READ_LATENCY),
    .RST_VAL (4'b0110)
  ) u_ctrl_dly (
    .clk     (clk),
    .rst     (reset),
    .sig     ({de_in, hsync_in, vsync_in, in_range}),
    .sig_dly (ctrl_p0)
  );

  always_comb begin
    pix_p0 = '0;
    if (ctrl_p0[3]) pix_p0 = ctrl_p0[0] ? rgb565_to_444(fb.rData) : rgb565_to_444(BLANK_COLOR);
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      de_out    <= 1'b0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
    end else begin
      de_out    <= ctrl_p0[3];
      hsync_out <= ctrl_p0[2];
      vsync_out <= ctrl_p0[1];
      r_out     <= pix_p0.r;
      g_out     <= pix_p0.g;
      b_out     <= pix_p0.b;
    end
  end

endmodule

// File: tb/tb_qvga_fb_reader.sv
// Randomized bench for qvga_fb_reader at READ_LATENCY 1 and 3 against a coordinate-based model.
module tb_qvga_fb_reader;
  import qvga_pkg::*;

  localparam int          NPIX   = 76800;
  localparam logic [15:0] BLANK1 = 16'h0000;
  localparam logic [15:0] BLANK3 = 16'h5AB3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, de_in, hsync_in, vsync_in;
  logic de_o1, hs_o1, vs_o1, de_o3, hs_o3, vs_o3;
  logic [3:0] r1, g1, b1, r3, g3, b3;

  qvga_fb_reader_if fb1 ();
  qvga_fb_reader_if fb3 ();

  qvga_fb_reader #(.READ_LATENCY(1), .BLANK_COLOR(BLANK1)) dut1 (
    .clk(clk), .reset(reset), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .fb(fb1), .de_out(de_o1), .hsync_out(hs_o1), .vsync_out(vs_o1),
    .r_out(r1), .g_out(g1), .b_out(b1));

  qvga_fb_reader #(.READ_LATENCY(3), .BLANK_COLOR(BLANK3)) dut3 (
    .clk(clk), .reset(reset), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .fb(fb3), .de_out(de_o3), .hsync_out(hs_o3), .vsync_out(vs_o3),
    .r_out(r3), .g_out(g3), .b_out(b3));

  // Frame-buffer memory with one-clock and three-clock read pipes
  logic [15:0] mem [NPIX];
  logic [15:0] p1;
  logic [15:0] p3 [3];
  always @(posedge clk) begin
    p1    <= (int'(fb1.rAddr) < NPIX) ? mem[fb1.rAddr] : 16'hDEAD;
    p3[0] <= (int'(fb3.rAddr) < NPIX) ? mem[fb3.rAddr] : 16'hDEAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign fb1.rData = p1;
  assign fb3.rData = p3[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          chk;
    bit          de, hs, vs, rng;
    logic [15:0] pix;
  } ent_t;

  ent_t hist [8];
  int   step_n = 0;
  int   mx = 0, my = 0;
  bit   synced = 0, prev_de = 0;

  function automatic logic [11:0] to444(input logic [15:0] p);
    return {p[15:12], p[10:7], p[4:1]};
  endfunction

  task automatic check_out(input string name, input int lat, input logic [15:0] blank,
                           input logic de_o, input logic hs_o, input logic vs_o,
                           input logic [11:0] rgb_o);
    int   idx;
    ent_t e;
    logic [11:0] exp_rgb;
    idx = step_n - lat - 1;
    if (idx < 0) return;
    e = hist[idx % 8];
    if (!e.chk) return;
    exp_rgb = e.de ? (e.rng ? to444(e.pix) : to444(blank)) : 12'h000;
    check_val({name, "_de_out"}, de_o, e.de);
    check_val({name, "_hsync_out"}, hs_o, e.hs);
    check_val({name, "_vsync_out"}, vs_o, e.vs);
    check_val({name, "_rgb"}, rgb_o, exp_rgb);
  endtask

  task automatic step(input logic d, input logic h, input logic v, input logic r);
    ent_t e;
    int   addr;
    bit   inr;
    @(negedge clk);
    check_out("L1", 1, BLANK1, de_o1, hs_o1, vs_o1, {r1, g1, b1});
    check_out("L3", 3, BLANK3, de_o3, hs_o3, vs_o3, {r3, g3, b3});
    reset = r; de_in = d; hsync_in = h; vsync_in = v;
    #1;
    inr  = synced && (mx < 640) && (my < 480);
    addr = (my / 2) * 320 + (mx / 2);
    if (synced) begin
      check_val("L1_oe", fb1.oe, d && inr);
      check_val("L3_oe", fb3.oe, d && inr);
      if (inr) begin
        check_val("L1_rAddr", fb1.rAddr, addr);
        check_val("L3_rAddr", fb3.rAddr, addr);
      end
    end
    check_val("L1_rAddr_bound", int'(fb1.rAddr) < NPIX, 1'b1);
    check_val("L3_rAddr_bound", int'(fb3.rAddr) < NPIX, 1'b1);
    e.chk = synced && !r;
    e.de  = d; e.hs = h; e.vs = v; e.rng = inr;
    e.pix = inr ? mem[addr] : 16'h0000;
    hist[step_n % 8] = e;
    if (r) begin
      for (int k = 0; k < 4; k++)
        if (step_n - k >= 0) hist[(step_n - k) % 8].chk = 0;
      synced = 0; mx = 0; my = 0; prev_de = 0;
    end else if (!v) begin
      synced = 1; mx = 0; my = 0; prev_de = d;
    end else if (prev_de && !d) begin
      my++; mx = 0; prev_de = d;
    end else begin
      if (d) mx++;
      prev_de = d;
    end
    step_n++;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic vsync_pulse();
    repeat (3) step(1'b0, rbit(), 1'b0, 1'b0);
    repeat (4) step(1'b0, rbit(), 1'b1, 1'b0);
  endtask

  task automatic line(input int width, input int gap);
    for (int i = 0; i < width; i++) step(1'b1, rbit(), 1'b1, 1'b0);
    for (int i = 0; i < gap; i++)   step(1'b0, rbit(), 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    for (int i = 0; i < NPIX; i++) mem[i] = 16'($urandom);
    repeat (4) step(1'b0, 1'b1, 1'b1, 1'b1);

    // Three full-width lines: address sequence, line repeat, next source line
    vsync_pulse();
    repeat (3) line(640, 12);

    // Colour mapping with a fixed magenta pixel everywhere
    for (int i = 0; i < NPIX; i++) mem[i] = 16'hF81F;
    vsync_pulse();
    for (int i = 0; i < 640; i++) begin
      step(1'b1, rbit(), 1'b1, 1'b0);
      if (i == 20) begin
        check_val("f81f_L1_r", r1, 4'hF); check_val("f81f_L1_g", g1, 4'h0);
        check_val("f81f_L1_b", b1, 4'hF); check_val("f81f_L3_r", r3, 4'hF);
        check_val("f81f_L3_g", g3, 4'h0); check_val("f81f_L3_b", b3, 4'hF);
      end
    end
    repeat (8) step(1'b0, rbit(), 1'b1, 1'b0);
    check_val("idle_L1_rgb", {de_o1, r1, g1, b1}, 13'h0);
    check_val("idle_L3_rgb", {de_o3, r3, g3, b3}, 13'h0);
    for (int i = 0; i < NPIX; i++) mem[i] = 16'($urandom);

    // Oversize frame: short lines race through, last lines are 700 wide, 500 lines
    vsync_pulse();
    for (int y = 0; y < 476; y++) line($urandom_range(1, 8), $urandom_range(1, 3));
    for (int y = 476; y < 500; y++) line(700, 8);

    // Mid-frame vsync during line 100, then vsync coinciding with a DE fall
    vsync_pulse();
    for (int y = 0; y < 100; y++) line($urandom_range(1, 6), 2);
    for (int i = 0; i < 640; i++) step(1'b1, rbit(), (i == 300 || i == 301) ? 1'b0 : 1'b1, 1'b0);
    repeat (6) step(1'b0, rbit(), 1'b1, 1'b0);
    line(640, 6);
    line(640, 6);
    line(30, 0);
    step(1'b0, rbit(), 1'b0, 1'b0);
    repeat (4) step(1'b0, rbit(), 1'b1, 1'b0);
    line(640, 6);

    // Reset in the middle of a line, then resynchronise on vsync
    vsync_pulse();
    line(640, 6);
    line(200, 0);
    step(1'b1, rbit(), 1'b1, 1'b1);
    @(posedge clk); #1;
    check_val("rst_L1_de", de_o1, 1'b0);   check_val("rst_L1_hs", hs_o1, 1'b1);
    check_val("rst_L1_vs", vs_o1, 1'b1);   check_val("rst_L1_rgb", {r1, g1, b1}, 12'h0);
    check_val("rst_L1_addr", fb1.rAddr, 0);
    check_val("rst_L3_de", de_o3, 1'b0);   check_val("rst_L3_hs", hs_o3, 1'b1);
    check_val("rst_L3_vs", vs_o3, 1'b1);   check_val("rst_L3_rgb", {r3, g3, b3}, 12'h0);
    check_val("rst_L3_addr", fb3.rAddr, 0);
    line(100, 6);
    vsync_pulse();
    line(640, 6);
    line(640, 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qvga_fb_reader.md
Name: qvga_fb_reader

Overview:
- Read-side counterpart of the frame-buffer write path: filters write 320x240 RGB565 pixels into the frame buffer, and this block reads them back out.
- Driven by the VGA timing generator (640x480). It generates frame-buffer read addresses incrementally (no multiplier) and upscales 2x by pixel/line doubling.
- Returns RGB444 plus sync/DE, delay-aligned to the memory read latency. Sits between the frame buffer read port and the VGA output pins.

Parameters:
- IMG_WIDTH, 320, source frame width in pixels.
- IMG_HEIGHT, 240, source frame height in lines.
- READ_LATENCY, 1, frame-buffer read latency in clocks (rAddr to rData); legal range 1..4.
- BLANK_COLOR, 16'h0000, RGB565 value output for active pixels outside the 2*IMG_WIDTH x 2*IMG_HEIGHT area.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- de_in  in  1  display-enable from the VGA timing generator.
- hsync_in  in  1  hsync from the timing generator; passed through only.
- vsync_in  in  1  vsync, active low; a low level marks vertical sync.
- oe  out  1  frame-buffer read enable; equals de_in AND in_range, combinational.
- rAddr  out  $clog2(IMG_WIDTH*IMG_HEIGHT)  frame-buffer read address; registered counter value.
- rData  in  16  RGB565 read data; valid READ_LATENCY clocks after oe.
- de_out  out  1  de_in delayed by READ_LATENCY+1.
- hsync_out  out  1  hsync_in delayed by READ_LATENCY+1.
- vsync_out  out  1  vsync_in delayed by READ_LATENCY+1.
- r_out, g_out, b_out  out  4 each  RGB444 pixel: rData[15:12], rData[10:7], rData[4:1]; 0 when de_out low.

Behaviour:
- Reset (synchronous) clears all registers and delay lines. Outputs reset to: rAddr=0, de_out=0, hsync_out=1, vsync_out=1, r/g/b=0.
- State registers:
  - addr_cnt: current address.
  - line_base: address of pixel 0 of the current source line.
  - h_dup, v_dup: 1-bit duplicate toggles.
  - src_y: source line counter.
  - de_d: previous de_in.
- rAddr = addr_cnt. The address presented in a cycle with de_in=1 belongs to that cycle's pixel.
- Horizontal doubling: each de_in=1 cycle toggles h_dup. When h_dup is 1 before the toggle, addr_cnt increments. Net effect: each address is held for 2 consecutive active pixels.
- Line end (de_d=1, de_in=0), with h_dup cleared:
  - v_dup=0: v_dup<=1, addr_cnt<=line_base (repeat the source line).
  - v_dup=1: v_dup<=0, line_base<=line_base+IMG_WIDTH, addr_cnt<=line_base+IMG_WIDTH, src_y<=src_y+1.
- Frame reset: any cycle with vsync_in=0 loads addr_cnt=0, line_base=0, h_dup=0, v_dup=0, src_y=0. It takes priority over line-end and pixel-advance logic in the same cycle.
- Range guard:
  - in_range = (src_y < IMG_HEIGHT) AND (addr_cnt - line_base < IMG_WIDTH).
  - If in_range=0: addr_cnt does not advance, line_base stays saturated, oe=0, and the delayed pixel output is BLANK_COLOR. This covers oversize timing.
- Output path:
  - de/hsync/vsync/in_range go through a (READ_LATENCY+1)-stage shift register.
  - rData is registered once.
  - Output colour is selected from the delayed in_range and de.
  - Total latency from de_in to de_out is exactly READ_LATENCY+1 clocks. All outputs are registered.
- Arithmetic: all address math is unsigned at rAddr width; line_base+IMG_WIDTH never exceeds IMG_WIDTH*IMG_HEIGHT.
- Reset mid-frame: the block resynchronises at the next vsync_in low, so output is well-defined but misaligned until then.
- A DE glitch shorter than 2 cycles is still treated as a line; no filtering.

Decomposition:
- Package qvga_pkg: IMG_WIDTH/IMG_HEIGHT defaults, FB_ADDR_W = $clog2(IMG_WIDTH*IMG_HEIGHT), RGB565-to-RGB444 conversion function.
- One sub-module: sync_delay_line (parameterised width and depth shift register), used for the de/hsync/vsync/in_range alignment.

Test Plan:
- Single active line (READ_LATENCY=1): vsync pulse, then de_in high for 640 cycles.
  - Expect rAddr sequence 0,0,1,1,...,319,319.
  - Expect de_out to rise exactly 2 clocks after de_in.
- Line doubling: two consecutive 640-pixel lines.
  - Second line starts at rAddr=0.
  - Third line starts at rAddr=320.
  - After 480 lines, line_base=76480.
- Colour mapping: rData=16'hF81F on every read.
  - Expect r_out=4'hF, g_out=4'h0, b_out=4'hF.
  - With de_out=0, all channels read 0.
- Oversize timing: de_in 700 cycles wide, 500 lines.
  - Pixels 640..699 and lines 480..499 give oe=0 and output BLANK_COLOR.
  - rAddr never exceeds 76799.
- Mid-frame vsync: vsync_in low during line 100.
  - Next line's rAddr=0 and v_dup=0.
  - Vsync in the same cycle as a DE falling edge: the frame reset wins.
- Reset/latency sweep: assert reset mid-line; outputs go to their reset values on the next edge.
  - Rerun the first scenario with READ_LATENCY=3; de_out lags de_in by exactly 4 clocks.
